run_length_logger: RTL and testbench
====================================

Name: run_length_logger

Overview:
- Downstream consumer of the history FSM. Samples the serial bit `a` and the FSM's Mealy outputs `x` and `y` on the same cycle.
- `x` means the current bit equals the previous bit. `y` means it equals the previous two bits.
- Converts the stream into run records {bit value, long-run flag, run length} and buffers them in a small FIFO.
- Records leave on a valid/ready interface to a host logger. Sticky flags report FIFO overflow and inconsistent x/y inputs.

Parameters:
- LEN_W, 8, width of the run-length field; length saturates at 2^LEN_W-1.
- DEPTH, 4, FIFO depth in records; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock shared with history FSM
- reset  input  1  synchronous, active-high reset
- a  input  1  serial bit, same cycle as presented to history FSM
- x  input  1  FSM output: a equals previous bit
- y  input  1  FSM output: a equals previous two bits
- out_valid  output  1  FIFO non-empty; head record presented
- out_ready  input  1  consumer accepts head when out_valid=1
- out_bit  output  1  bit value of head run
- out_long  output  1  head run reached length >=3 (y seen)
- out_len  output  LEN_W  head run length, 1..2^LEN_W-1
- level  output  $clog2(DEPTH+1)  records held
- overflow  output  1  sticky: record dropped on full FIFO
- err  output  1  sticky: x/y protocol violation

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - run_active=0, cur_len=0, cur_bit=0, cur_long=0.
  - FIFO emptied.
  - Outputs: out_valid=0, out_bit=0, out_long=0, out_len=0, level=0, overflow=0, err=0.
- Reset mid-operation drops the open run and all buffered records. No emission occurs on the reset edge.
- Run tracker, evaluated every cycle with reset=0; there is no input valid, the stream advances every clock:
  - x=1 and run_active=1: cur_len <= min(cur_len+1, 2^LEN_W-1); cur_long <= cur_long | y.
  - x=0 and run_active=1: emit record {cur_bit, cur_long, cur_len}. Start a new run: cur_bit<=a, cur_len<=1, cur_long<=0.
  - x=0 and run_active=0 (first cycle after reset): start a run as above with no emission; run_active<=1.
- Protocol checks; err is set the next cycle and held until reset:
  - y=1 with x=0.
  - x=1 with run_active=0.
  - x=1 with a != cur_bit.
  - On x=1 with run_active=0, the tracker treats the cycle as x=0: it starts a run and emits nothing.
- Latency: a run ends on the cycle x=0. Its record appears at the FIFO head on the next cycle if the FIFO was empty; out_valid rises that cycle.
- FIFO:
  - Push = emit. Pop = out_valid & out_ready.
  - Push and pop in the same cycle are both performed, including when full; level is unchanged.
  - Push while full without a pop drops the record and sets overflow.
  - Pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
  - out_* are driven directly from the head entry. out_bit, out_long and out_len read 0 when empty.
- Saturation: the length field stays at max and the run continues; no error is raised.

Decomposition:
- Package run_pkg:
  - LEN_W_DEF constant.
  - Packed struct run_rec_t {bit_v, long_v, len[LEN_W-1:0]}.
  - Function sat_inc.
- Sub-module run_fifo: parameterised synchronous FIFO of run_rec_t with push/pop/full/empty/level. Tracker and checks stay in the top level.

Test Plan:
- Reset, then a=0,0,0,1,1,0 through a live history FSM (x=0,1,1,0,1,0; y=0,0,1,0,0,0) -> records {0,1,3} then {1,0,2}. out_valid first rises in the cycle after the 4th sample; err=0.
- Alternating a=0,1,0,1,... with out_ready=0 -> every cycle after the first emits len=1. level reaches 4; the 5th record is dropped and overflow=1. Head stays the first record {0,0,1}.
- 300 consecutive a=1, then a=0 -> out_len=255, out_long=1, out_bit=1; no err.
- FIFO full (level=4) with out_ready=1 and an emit in the same cycle -> level stays 4, overflow stays 0, head advances to the 2nd record.
- Drive x=1 in the first cycle after reset -> err=1 next cycle and held; separately drive y=1, x=0 -> err=1.
- Reset asserted with 3 records queued and a run open -> next cycle level=0, out_valid=0, overflow=0, err=0. The first post-reset run starts fresh at len=1.

Source files
------------

// File: rtl/run_pkg.sv
// Shared types and helpers for the run-length logger: the run record layout
// and a saturating increment used by the run-length counter.
package run_pkg;

    localparam int LEN_W_DEF = 8;

    // One finished run: its bit value, whether it ever reached length 3,
    // and its (saturated) length.
    typedef struct packed {
        logic                 bit_v;
        logic                 long_v;
        logic [LEN_W_DEF-1:0] len;
    } run_rec_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/run_fifo.sv
// Small synchronous FIFO of run records. A push into a full FIFO is only
// accepted when a pop happens in the same cycle; otherwise the record is
// dropped and flagged on 'drop'. The head is presented combinationally
// and reads as zero while empty.
module run_fifo
    import run_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = run_rec_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  rec_t                       push_data,
    input  logic                       pop,
    output rec_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Decide which of push/pop take effect and compute the next storage state.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == LVL_W'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        drop     = push & full & ~do_pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        head  = empty ? '0 : mem_q[rd_ptr_q];
        level = count_q;
    end

    // Storage and pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/run_length_logger.sv
// Turns the serial bit stream plus the history FSM's x/y outputs into run
// records and queues them for a host logger. Also keeps sticky flags for
// dropped records and for x/y values that contradict the stream.
module run_length_logger
    import run_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a,
    input  logic                       x,
    input  logic                       y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_bit,
    output logic                       out_long,
    output logic [LEN_W-1:0]           out_len,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       err
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef struct packed {
        logic             bit_v;
        logic             long_v;
        logic [LEN_W-1:0] len;
    } rec_t;

    logic             run_active_q, run_active_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic             cur_bit_q, cur_bit_d;
    logic             cur_long_q, cur_long_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
    logic             emit;
    rec_t             emit_rec;
    rec_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;

    // Run tracker: extend the open run while x=1, otherwise close it (emitting
    // a record if one was open) and start a new run at the current bit.
    // Also accumulate the sticky error and overflow flags.
    always_comb begin
        run_active_d = run_active_q;
        cur_len_d    = cur_len_q;
        cur_bit_d    = cur_bit_q;
        cur_long_d   = cur_long_q;
        emit         = 1'b0;
        emit_rec     = '{bit_v: cur_bit_q, long_v: cur_long_q, len: cur_len_q};
        if (x && run_active_q) begin
            cur_len_d  = LEN_W'(sat_inc(32'(cur_len_q), 32'(LEN_MAX)));
            cur_long_d = cur_long_q | y;
        end else begin
            emit         = run_active_q;
            cur_bit_d    = a;
            cur_len_d    = LEN_W'(1);
            cur_long_d   = 1'b0;
            run_active_d = 1'b1;
        end
        err_d = err_q
              | (y & ~x)
              | (x & ~run_active_q)
              | (x & run_active_q & (a != cur_bit_q));
        overflow_d = overflow_q | fifo_drop;
    end

    // Tracker and flag registers; reset drops the open run and clears flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_active_q <= 1'b0;
            cur_len_q    <= '0;
            cur_bit_q    <= 1'b0;
            cur_long_q   <= 1'b0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            run_active_q <= run_active_d;
            cur_len_q    <= cur_len_d;
            cur_bit_q    <= cur_bit_d;
            cur_long_q   <= cur_long_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
        end
    end

    run_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (emit_rec),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .drop      (fifo_drop)
    );

    assign out_valid = ~fifo_empty;
    assign out_bit   = head.bit_v;
    assign out_long  = head.long_v;
    assign out_len   = head.len;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule

// File: tb/tb_run_length_logger.sv
// Directed bench for run_length_logger. A tiny history-FSM model produces
// x/y from the bit stream; expected records are worked out by hand.
module tb_run_length_logger;

    logic       clk;
    logic       reset;
    logic       a;
    logic       x;
    logic       y;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_long;
    logic [7:0] out_len;
    logic [2:0] level;
    logic       overflow;
    logic       err;

    int check_count;
    int pass_count;

    logic prev1;
    logic prev2;
    int   hist_n;

    run_length_logger #(.LEN_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_long  (out_long),
        .out_len   (out_len),
        .level     (level),
        .overflow  (overflow),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive raw a/x/y for one clock, then settle 1ns past the edge.
    task automatic apply_stimulus(input logic b, input logic xv, input logic yv);
        a = b;
        x = xv;
        y = yv;
        @(posedge clk);
        #1;
        prev2 = prev1;
        prev1 = b;
        if (hist_n < 2) hist_n++;
    endtask

    // Feed one bit with x/y produced by a live history FSM.
    task automatic feed_bit(input logic b);
        logic xv;
        logic yv;
        xv = (hist_n >= 1) && (b == prev1);
        yv = (hist_n >= 2) && (b == prev1) && (b == prev2);
        apply_stimulus(b, xv, yv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a = 1'b0;
        x = 1'b0;
        y = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        hist_n = 0;
        prev1  = 1'b0;
        prev2  = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic b, input logic l, input int len);
        check_output({tag, ".bit"},  32'(out_bit),  32'(b));
        check_output({tag, ".long"}, 32'(out_long), 32'(l));
        check_output({tag, ".len"},  32'(out_len),  32'(len));
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        // Reset state
        do_reset();
        check_output("rst.valid",    32'(out_valid), 0);
        check_output("rst.level",    32'(level),     0);
        check_output("rst.len",      32'(out_len),   0);
        check_output("rst.overflow", 32'(overflow),  0);
        check_output("rst.err",      32'(err),       0);

        // Stream 0,0,0,1,1,0 -> {0,1,3} then {1,0,2}
        feed_bit(1'b0);
        feed_bit(1'b0);
        feed_bit(1'b0);
        check_output("t1.valid_early", 32'(out_valid), 0);
        feed_bit(1'b1);
        check_output("t1.valid_rise", 32'(out_valid), 1);
        check_head("t1.rec1", 1'b0, 1'b1, 3);
        feed_bit(1'b1);
        feed_bit(1'b0);
        check_output("t1.level2", 32'(level), 2);
        out_ready = 1'b1;
        feed_bit(1'b0);
        out_ready = 1'b0;
        check_output("t1.level1", 32'(level), 1);
        check_head("t1.rec2", 1'b1, 1'b0, 2);
        check_output("t1.err", 32'(err), 0);

        // Alternating bits with no consumer: fill, then overflow
        do_reset();
        for (int i = 0; i < 5; i++) feed_bit(1'(i % 2));
        check_output("t2.level4", 32'(level), 4);
        check_output("t2.ovf_pre", 32'(overflow), 0);
        feed_bit(1'b1);
        check_output("t2.level_full", 32'(level), 4);
        check_output("t2.overflow", 32'(overflow), 1);
        check_head("t2.head", 1'b0, 1'b0, 1);

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 5; i++) feed_bit(1'(i % 2));
        out_ready = 1'b1;
        feed_bit(1'b1);
        out_ready = 1'b0;
        check_output("t4.level", 32'(level), 4);
        check_output("t4.overflow", 32'(overflow), 0);
        check_head("t4.head", 1'b1, 1'b0, 1);

        // 300 ones then a zero: length saturates
        do_reset();
        for (int i = 0; i < 300; i++) feed_bit(1'b1);
        check_output("t3.no_emit", 32'(out_valid), 0);
        feed_bit(1'b0);
        check_output("t3.valid", 32'(out_valid), 1);
        check_head("t3.sat", 1'b1, 1'b1, 255);
        check_output("t3.err", 32'(err), 0);

        // x=1 right after reset
        do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t5.err_x", 32'(err), 1);
        check_output("t5.no_emit", 32'(level), 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("t5.err_held", 32'(err), 1);

        // y=1 with x=0
        do_reset();
        feed_bit(1'b0);
        check_output("t5.err_clean", 32'(err), 0);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("t5.err_y", 32'(err), 1);

        // x=1 while a differs from the open run's bit
        do_reset();
        feed_bit(1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("t5.err_bit", 32'(err), 1);

        // Reset with records queued and a run open
        do_reset();
        feed_bit(1'b0);
        feed_bit(1'b1);
        feed_bit(1'b0);
        feed_bit(1'b1);
        check_output("t6.level_pre", 32'(level), 3);
        do_reset();
        check_output("t6.level", 32'(level), 0);
        check_output("t6.valid", 32'(out_valid), 0);
        check_output("t6.overflow", 32'(overflow), 0);
        check_output("t6.err", 32'(err), 0);
        feed_bit(1'b1);
        feed_bit(1'b1);
        feed_bit(1'b0);
        check_head("t6.fresh", 1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
